// File: rtl/alert_event_controller.sv
// alert_event_controller: captures calamity, zone and lockout events, serialises them onto one
// valid/ready channel, and drives the sticky siren/exit outputs and the keypad lockout logic.
module alert_event_controller #(
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    parameter int SIREN_MIN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire_in,
    input  logic       quake_in,
    input  logic [3:0] zone_in,
    input  logic       acc_valid,
    input  logic       acc_match,
    input  logic       clear,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       siren,
    output logic       exit_open,
    output logic       door_unlock,
    output logic       locked
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int SW = $clog2(SIREN_MIN + 1);
    localparam logic [FW-1:0] MAXF_M1 = FW'(MAX_FAILS - 1);
    localparam logic [LW-1:0] LMAX = LW'(LOCK_CYCLES);
    localparam logic [SW-1:0] SMAX = SW'(SIREN_MIN);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        state_q, state_d;
    logic [6:0]    pend_q, pend_d, set_v, clr_v;
    logic [5:0]    hist_q, cur, rise;
    logic [3:0]    zones;
    logic [1:0]    rr_q, rr_d, zwin, idx;
    logic [2:0]    code_q, code_d, win;
    logic [FW-1:0] fails_q, fails_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [SW-1:0] stmr_q, stmr_d;
    logic          siren_q, siren_d, exit_q, exit_d, pulse_q, pulse_d;
    logic          attempt, lock_evt, clr_ok, cal;

    assign cur      = {zone_in, quake_in, fire_in};
    assign rise     = cur & ~hist_q;
    assign attempt  = acc_valid && lock_q == '0;
    assign lock_evt = attempt && !acc_match && fails_q == MAXF_M1;
    assign set_v    = {lock_evt, rise};
    assign clr_v    = (state_q == OFFER && evt_ready) ? 7'd1 << code_q : 7'd0;
    assign pend_d   = (pend_q & ~clr_v) | set_v;
    assign zones    = pend_q[5:2];
    assign cal      = rise[0] | rise[1];
    assign clr_ok   = clear && !fire_in && !quake_in && stmr_q == SMAX;

    // Round-robin zone pick: scan downward so the slot nearest the pointer wins last.
    always_comb begin
        zwin = rr_q;
        idx  = rr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (zones[idx]) zwin = idx;
        end
        win = pend_q[0] ? 3'd0 : pend_q[1] ? 3'd1 : pend_q[6] ? 3'd6 : 3'd2 + {1'b0, zwin};
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rr_d    = rr_q;
        if (state_q == IDLE) begin
            if (|pend_q) begin
                state_d = OFFER;
                code_d  = win;
            end
        end else if (evt_ready) begin
            state_d = IDLE;
            if (code_q >= 3'd2 && code_q <= 3'd5) rr_d = 2'(code_q - 3'd1);
        end
    end

    always_comb begin
        fails_d = attempt ? ((acc_match || lock_evt) ? '0 : fails_q + FW'(1)) : fails_q;
        pulse_d = attempt && acc_match;
        lock_d  = lock_evt ? LMAX : (lock_q != '0) ? lock_q - LW'(1) : lock_q;
        siren_d = cal || lock_evt || (siren_q && !clr_ok);
        exit_d  = cal || (exit_q && !clr_ok);
        stmr_d  = (siren_q && !clr_ok) ? ((stmr_q == SMAX) ? stmr_q : stmr_q + SW'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            hist_q  <= '0;
            rr_q    <= '0;
            code_q  <= '0;
            fails_q <= '0;
            lock_q  <= '0;
            stmr_q  <= '0;
            siren_q <= 1'b0;
            exit_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            hist_q  <= cur;
            rr_q    <= rr_d;
            code_q  <= code_d;
            fails_q <= fails_d;
            lock_q  <= lock_d;
            stmr_q  <= stmr_d;
            siren_q <= siren_d;
            exit_q  <= exit_d;
            pulse_q <= pulse_d;
        end
    end

    assign evt_valid   = state_q == OFFER;
    assign evt_code    = code_q;
    assign siren       = siren_q;
    assign exit_open   = exit_q;
    assign door_unlock = pulse_q | exit_q;
    assign locked      = lock_q != '0;
endmodule

// File: tb/tb_alert_event_controller.sv
// tb_alert_event_controller: directed vectors; expected event codes go into a queue that a
// monitor drains on every accepted handshake, plus direct checks of the sticky outputs.
module tb_alert_event_controller;
    logic       clk = 1'b0;
    logic       rst, fire_in, quake_in, acc_valid, acc_match, clear, evt_ready;
    logic [3:0] zone_in;
    logic       evt_valid, siren, exit_open, door_unlock, locked;
    logic [2:0] evt_code;
    int         vectors = 0, miscompares = 0;
    logic [2:0] exp_q[$];

    alert_event_controller dut (
        .clk(clk), .rst(rst), .fire_in(fire_in), .quake_in(quake_in), .zone_in(zone_in),
        .acc_valid(acc_valid), .acc_match(acc_match), .clear(clear), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_code(evt_code), .siren(siren), .exit_open(exit_open),
        .door_unlock(door_unlock), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got code %0d expected none", evt_code);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (evt_code !== e) begin
                    miscompares++;
                    $display("FAIL event_code: got %0d expected %0d", evt_code, e);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; fire_in = 1'b1; quake_in = 1'b0; zone_in = 4'b0;
        acc_valid = 1'b0; acc_match = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        tick(2);
        check("rst_valid", evt_valid, 0);
        check("rst_siren", siren, 0);
        check("rst_door", door_unlock, 0);
        check("rst_locked", locked, 0);
        // fire already high at reset release counts as an event
        exp_q.push_back(3'd0);
        rst = 1'b0;
        tick(1);
        check("t1_valid_edge1", evt_valid, 0);
        check("t1_siren", siren, 1);
        check("t1_exit", exit_open, 1);
        check("t1_door", door_unlock, 1);
        tick(1);
        check("t1_valid_edge2", evt_valid, 1);
        check("t1_code", evt_code, 0);
        evt_ready = 1'b1;
        tick(3);
        fire_in = 1'b0;
        // all four zones at once: round-robin from zone0
        zone_in = 4'b1111;
        exp_q.push_back(3'd2); exp_q.push_back(3'd3);
        exp_q.push_back(3'd4); exp_q.push_back(3'd5);
        tick(1);
        zone_in = 4'b0;
        tick(12);
        zone_in = 4'b0001;
        exp_q.push_back(3'd2);
        tick(1);
        zone_in = 4'b0;
        tick(5);
        // hold offer under backpressure while fire arrives
        evt_ready = 1'b0;
        zone_in = 4'b0010;
        exp_q.push_back(3'd3);
        tick(1);
        zone_in = 4'b0;
        fire_in = 1'b1;
        exp_q.push_back(3'd0);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", evt_valid, 1);
            check("t3_hold_code", evt_code, 3);
            tick(1);
        end
        evt_ready = 1'b1;
        tick(6);
        fire_in = 1'b0;
        tick(20);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("fire_clear_siren", siren, 0);
        check("fire_clear_exit", exit_open, 0);
        check("fire_clear_door", door_unlock, 0);
        // three mismatches -> lockout
        exp_q.push_back(3'd6);
        acc_valid = 1'b1; acc_match = 1'b0;
        tick(3);
        check("t4_locked", locked, 1);
        check("t4_siren", siren, 1);
        acc_match = 1'b1;
        tick(1);
        n = 1;
        acc_valid = 1'b0;
        check("t4_no_unlock", door_unlock, 0);
        while (locked && n < 2000) begin
            tick(1);
            n++;
        end
        check("t4_lock_cycles", n, 1000);
        // match clears the fail count
        acc_valid = 1'b1; acc_match = 1'b0;
        tick(1);
        acc_match = 1'b1;
        tick(1);
        check("t5_unlock_pulse", door_unlock, 1);
        acc_match = 1'b0;
        tick(1);
        check("t5_unlock_end", door_unlock, 0);
        tick(1);
        acc_valid = 1'b0;
        tick(1);
        check("t5_no_lock", locked, 0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("lock_clear_siren", siren, 0);
        // quake: early clear ignored, later clear honoured
        quake_in = 1'b1;
        exp_q.push_back(3'd1);
        tick(1);
        quake_in = 1'b0;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t6_early_siren", siren, 1);
        check("t6_early_exit", exit_open, 1);
        tick(14);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t6_late_siren", siren, 0);
        check("t6_late_exit", exit_open, 0);
        check("t6_queue_drained", exp_q.size(), 0);
        // reset during an offer drops the event
        evt_ready = 1'b0;
        zone_in = 4'b0100;
        tick(1);
        zone_in = 4'b0;
        tick(1);
        check("t6_offer", evt_valid, 1);
        rst = 1'b1;
        tick(1);
        check("t6_rst_drop", evt_valid, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        tick(5);
        check("t6_no_replay", evt_valid, 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
